serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor computing diff = a − b over W cycles, one bit per clock, LSB first, through a single full-subtractor cell. It sits beside the mux-based full-adder datapath and provides the inverse operation with a start/done handshake, trading latency for a one-bit-wide arithmetic core.

---
 rtl/serial_subtractor_pkg.sv | 14 +
 rtl/serial_subtractor_if.sv | 37 +++
 rtl/serial_subtractor_full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
//   state_t   : FSM state encoding (IDLE/RUN/DONE)
//   DEFAULT_W : default operand/result width
package serial_sub_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
//   start, a, b             : request and operands (master -> slave)
//   busy, done, diff, bout  : status and result (slave -> master)
//   ovf                     : signed overflow, present only with SERIAL_SUB_OVF_EN
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    modport master (
        output start, a, b,
        input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: d = x - y - bin, bo = borrow out.
//   x, y, bin : minuend bit, subtrahend bit, borrow in
//   d, bo     : difference bit, borrow out
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bin;
    assign bo = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b over W clocks, LSB
// first, through a single full_subtractor cell.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_subtractor_if.slave (start/a/b in; busy/done/diff/bout out)
// Optional: SERIAL_SUB_OVF_EN adds the signed-overflow output bus.ovf.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one bit per clock through the cell, W clocks
// DONE  | single-cycle done pulse; start here chains straight into RUN
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(W);

    state_t          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    diff_sh_q, diff_sh_d;
    logic [W-1:0]    diff_q, diff_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            br_q, br_d;
    logic            bout_q, bout_d;
    logic            cell_d, cell_bo;
    logic            last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic            ovf_q, ovf_d;
`endif

    full_subtractor u_cell (
        .x   (a_sh_q[0]),
        .y   (b_sh_q[0]),
        .bin (br_q),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    assign last_bit = (cnt_q == CW'(W - 1));

    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        diff_sh_d = diff_sh_q;
        diff_d    = diff_q;
        cnt_d     = cnt_q;
        br_d      = br_q;
        bout_d    = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        sa_d      = sa_q;
        sb_d      = sb_q;
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    a_sh_d    = bus.a;
                    b_sh_d    = bus.b;
                    diff_sh_d = '0;
                    cnt_d     = '0;
                    br_d      = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                    sa_d      = bus.a[W-1];
                    sb_d      = bus.b[W-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d    = a_sh_q >> 1;
                b_sh_d    = b_sh_q >> 1;
                // new bit enters at the MSB so the LSB ends up at bit 0 after W shifts
                diff_sh_d = (diff_sh_q >> 1) | (W'(cell_d) << (W - 1));
                br_d      = cell_bo;
                cnt_d     = cnt_q + 1'b1;
                if (last_bit) begin
                    state_d = DONE;
                    diff_d  = diff_sh_d;
                    bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (sa_q != sb_q) && (cell_d != sa_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            diff_sh_q <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            br_q      <= 1'b0;
            bout_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            diff_sh_q <= diff_sh_d;
            diff_q    <= diff_d;
            cnt_q     <= cnt_d;
            br_q      <= br_d;
            bout_q    <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed, table-driven bench for serial_subtractor (W=8) plus an
// exhaustive check of the full_subtractor cell.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    localparam int W = DEFAULT_W;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    serial_subtractor_if #(.W(W)) bus ();

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic fx, fy, fb, fd, fbo;
    full_subtractor u_fs (.x(fx), .y(fy), .bin(fb), .d(fd), .bo(fbo));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one request, then wait (bounded) for done; lat counts edges after the accept edge.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output logic timeout);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
        lat     = 0;
        timeout = 1'b1;
        for (int n = 1; n <= 3 * W; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat     = n;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    vec_t vecs[11];

    initial begin
        int   lat;
        logic to;
        int   dcount;
        logic [W-1:0] dval;
        int   cyc, first_done, second_done;

        vecs[0]  = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1]  = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2]  = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3]  = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
        vecs[4]  = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[5]  = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[6]  = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};
        vecs[7]  = '{8'h55, 8'hAA, 8'hAB, 1'b1, 1'b1};
        vecs[8]  = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
        vecs[10] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_diff", {24'd0, bus.diff}, 32'd0);
        chk("rst_bout", {31'd0, bus.bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // bit cell, all 8 combinations against integer subtraction
        for (int i = 0; i < 8; i++) begin
            int r;
            fx = i[2];
            fy = i[1];
            fb = i[0];
            r  = int'(fx) - int'(fy) - int'(fb);
            #1;
            chk($sformatf("cell%0d_d", i), {31'd0, fd}, {31'd0, r[0]});
            chk($sformatf("cell%0d_bo", i), {31'd0, fbo}, (r < 0) ? 32'd1 : 32'd0);
        end

        // vector table
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, to);
            chk($sformatf("v%0d_timeout", i), {31'd0, to}, 32'd0);
            chk($sformatf("v%0d_latency", i), lat, W);
            chk($sformatf("v%0d_diff", i), {24'd0, bus.diff}, {24'd0, vecs[i].diff});
            chk($sformatf("v%0d_bout", i), {31'd0, bus.bout}, {31'd0, vecs[i].bout});
`ifdef SERIAL_SUB_OVF_EN
            chk($sformatf("v%0d_ovf", i), {31'd0, bus.ovf}, {31'd0, vecs[i].ovf});
`endif
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_single", i), {31'd0, bus.done}, 32'd0);
        end

        // start during RUN is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h00;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dcount = 0;
        dval   = '0;
        for (int n = 0; n < 2 * W + 4; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dcount++;
                dval = bus.diff;
            end
        end
        chk("ignore_done_count", dcount, 1);
        chk("ignore_diff", {24'd0, dval}, 32'h0F);
        chk("ignore_bout", {31'd0, bus.bout}, 32'd0);

        // asynchronous reset mid-RUN
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'hAA;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done", {31'd0, bus.done}, 32'd0);
        chk("arst_diff", {24'd0, bus.diff}, 32'd0);
        chk("arst_bout", {31'd0, bus.bout}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        chk("arst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(posedge clk);
        #1;
        chk("post_rst_idle_done", {31'd0, bus.done}, 32'd0);
        chk("post_rst_idle_busy", {31'd0, bus.busy}, 32'd0);
        run_op(8'h00, 8'h00, lat, to);
        chk("post_rst_timeout", {31'd0, to}, 32'd0);
        chk("post_rst_latency", lat, W);
        chk("post_rst_diff", {24'd0, bus.diff}, 32'd0);
        chk("post_rst_bout", {31'd0, bus.bout}, 32'd0);
        repeat (2) @(posedge clk);

        // back-to-back with start held through DONE
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        cyc         = 0;
        first_done  = -1;
        second_done = -1;
        for (int n = 0; n < 4 * W; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) begin
                if (first_done < 0) begin
                    first_done = cyc;
                    chk("b2b_first_diff", {24'd0, bus.diff}, 32'h02);
                    bus.a = 8'h03;
                    bus.b = 8'h05;
                end else begin
                    second_done = cyc;
                    break;
                end
            end else if (first_done >= 0) begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("b2b_seen_both", (first_done >= 0 && second_done >= 0) ? 32'd1 : 32'd0, 32'd1);
        chk("b2b_gap", second_done - first_done, W + 1);
        chk("b2b_second_diff", {24'd0, bus.diff}, 32'hFE);
        chk("b2b_second_bout", {31'd0, bus.bout}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
